// File: rtl/photon_lockin_counter.sv
// Purpose: lock-in photon counter; modulates a light source, bins PMT events by phase, integrates I/Q per window.
// Latency: pmt_in edge to accumulator 3 cycles; results appear the cycle after the window-end cycle.
// Backpressure: none; results are latched and held until the next result_valid pulse.
module photon_lockin_counter #(
    parameter int PERIOD_CYCLES = 500,
    parameter int NUM_BINS      = 4,
    parameter int COUNT_W       = 32,
    parameter int INTEG_CYCLES  = 50000000
) (
    input  logic                        main_clock,
    input  logic                        reset,
    input  logic                        pmt_in,
    output logic                        light_out,
    input  logic [$clog2(NUM_BINS)-1:0] bin_sel,
    output logic [COUNT_W-1:0]          bin_count,
    output logic signed [COUNT_W:0]     i_value,
    output logic signed [COUNT_W:0]     q_value,
    output logic [COUNT_W-1:0]          total_count,
    output logic                        result_valid,
    output logic                        overflow,
    output logic [15:0]                 window_index
);

    localparam int PH_W    = $clog2(PERIOD_CYCLES);
    localparam int IN_W    = $clog2(INTEG_CYCLES);
    localparam int BIN_W   = $clog2(NUM_BINS);
    localparam int BIN_LEN = PERIOD_CYCLES / NUM_BINS;
    localparam int SUB_W   = (BIN_LEN > 1) ? $clog2(BIN_LEN) : 1;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PERIOD_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(PERIOD_CYCLES / 2);
    localparam logic [PH_W-1:0]  PH_Q1    = PH_W'(PERIOD_CYCLES / 4);
    localparam logic [PH_W-1:0]  PH_Q3    = PH_W'((3 * PERIOD_CYCLES) / 4);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BIN_LEN - 1);
    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(INTEG_CYCLES - 1);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v, input logic en);
        if (en && !(&v)) begin
            return v + COUNT_W'(1);
        end
        return v;
    endfunction

    // Synchroniser and edge detector state. r_sync_vld tracks which sync
    // stages hold genuine post-reset samples, so a pmt_in already high
    // when reset releases is not mistaken for a fresh rising edge.
    logic       r_sync1;
    logic       r_sync2;
    logic       r_sync3;
    logic [2:0] r_sync_vld;
    logic       w_event;

    // Phase timer, sub-bin counter and current bin index.
    logic [PH_W-1:0]  r_phase;
    logic [SUB_W-1:0] r_sub;
    logic [BIN_W-1:0] r_bin;
    logic             r_light;

    // Integration timer.
    logic [IN_W-1:0] r_integ;
    logic            w_win_end;

    // Live accumulators for the open window.
    logic [COUNT_W-1:0] r_ip;
    logic [COUNT_W-1:0] r_im;
    logic [COUNT_W-1:0] r_qp;
    logic [COUNT_W-1:0] r_qm;
    logic [COUNT_W-1:0] r_tot;
    logic [COUNT_W-1:0] r_bins [NUM_BINS];
    logic               r_ovf;

    // Accumulator values including the current cycle's event.
    logic               w_in_phase;
    logic               w_quad;
    logic [COUNT_W-1:0] w_ip_nxt;
    logic [COUNT_W-1:0] w_im_nxt;
    logic [COUNT_W-1:0] w_qp_nxt;
    logic [COUNT_W-1:0] w_qm_nxt;
    logic [COUNT_W-1:0] w_tot_nxt;
    logic [COUNT_W-1:0] w_bins_nxt [NUM_BINS];
    logic               w_bin_sat;
    logic               w_ovf_nxt;
    logic signed [COUNT_W:0] w_i_diff;
    logic signed [COUNT_W:0] w_q_diff;

    // Latched results of the last completed window.
    logic signed [COUNT_W:0] r_i_value;
    logic signed [COUNT_W:0] r_q_value;
    logic [COUNT_W-1:0]      r_total;
    logic [COUNT_W-1:0]      r_bank [NUM_BINS];
    logic                    r_ovf_lat;
    logic                    r_valid;
    logic [15:0]             r_win_idx;

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge main_clock) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync3    <= 1'b0;
            r_sync_vld <= 3'b000;
        end else begin
            r_sync1    <= pmt_in;
            r_sync2    <= r_sync1;
            r_sync3    <= r_sync2;
            r_sync_vld <= {r_sync_vld[1:0], 1'b1};
        end
    end

    assign w_event = r_sync2 & ~r_sync3 & r_sync_vld[2];

    // Free-running phase timer; never disturbed by window boundaries.
    always_ff @(posedge main_clock) begin
        if (reset) begin
            r_phase <= '0;
            r_sub   <= '0;
            r_bin   <= '0;
            r_light <= 1'b0;
        end else begin
            r_light <= (r_phase < PH_HALF);
            if (r_phase == PH_LAST) begin
                r_phase <= '0;
                r_sub   <= '0;
                r_bin   <= '0;
            end else begin
                r_phase <= r_phase + PH_W'(1);
                if (r_sub == SUB_LAST) begin
                    r_sub <= '0;
                    r_bin <= r_bin + BIN_W'(1);
                end else begin
                    r_sub <= r_sub + SUB_W'(1);
                end
            end
        end
    end

    assign w_win_end = (r_integ == IN_LAST);

    // Integration window timer.
    always_ff @(posedge main_clock) begin
        if (reset) begin
            r_integ <= '0;
        end else if (w_win_end) begin
            r_integ <= '0;
        end else begin
            r_integ <= r_integ + IN_W'(1);
        end
    end

    // Phase classification and next accumulator values for this cycle's event.
    always_comb begin
        w_in_phase = (r_phase < PH_HALF);
        w_quad     = (r_phase >= PH_Q1) && (r_phase < PH_Q3);
        w_ip_nxt   = sat_inc(r_ip,  w_event &  w_in_phase);
        w_im_nxt   = sat_inc(r_im,  w_event & ~w_in_phase);
        w_qp_nxt   = sat_inc(r_qp,  w_event &  w_quad);
        w_qm_nxt   = sat_inc(r_qm,  w_event & ~w_quad);
        w_tot_nxt  = sat_inc(r_tot, w_event);
        w_bin_sat  = 1'b0;
        for (int b = 0; b < NUM_BINS; b++) begin
            w_bins_nxt[b] = sat_inc(r_bins[b], w_event && (r_bin == BIN_W'(b)));
            w_bin_sat     = w_bin_sat | (w_event && (r_bin == BIN_W'(b)) && (&r_bins[b]));
        end
        w_ovf_nxt = r_ovf
                  | (w_event &  w_in_phase & (&r_ip))
                  | (w_event & ~w_in_phase & (&r_im))
                  | (w_event &  w_quad     & (&r_qp))
                  | (w_event & ~w_quad     & (&r_qm))
                  | (w_event & (&r_tot))
                  | w_bin_sat;
        w_i_diff = $signed({1'b0, w_ip_nxt}) - $signed({1'b0, w_im_nxt});
        w_q_diff = $signed({1'b0, w_qp_nxt}) - $signed({1'b0, w_qm_nxt});
    end

    // Accumulators: take the next value, or restart from zero after window end.
    always_ff @(posedge main_clock) begin
        if (reset || w_win_end) begin
            r_ip  <= '0;
            r_im  <= '0;
            r_qp  <= '0;
            r_qm  <= '0;
            r_tot <= '0;
            r_ovf <= 1'b0;
            for (int b = 0; b < NUM_BINS; b++) begin
                r_bins[b] <= '0;
            end
        end else begin
            r_ip  <= w_ip_nxt;
            r_im  <= w_im_nxt;
            r_qp  <= w_qp_nxt;
            r_qm  <= w_qm_nxt;
            r_tot <= w_tot_nxt;
            r_ovf <= w_ovf_nxt;
            for (int b = 0; b < NUM_BINS; b++) begin
                r_bins[b] <= w_bins_nxt[b];
            end
        end
    end

    // Result bank: captures the closing window, including its last-cycle event.
    always_ff @(posedge main_clock) begin
        if (reset) begin
            r_i_value <= '0;
            r_q_value <= '0;
            r_total   <= '0;
            r_ovf_lat <= 1'b0;
            r_valid   <= 1'b0;
            r_win_idx <= '0;
            for (int b = 0; b < NUM_BINS; b++) begin
                r_bank[b] <= '0;
            end
        end else begin
            r_valid <= w_win_end;
            if (w_win_end) begin
                r_i_value <= w_i_diff;
                r_q_value <= w_q_diff;
                r_total   <= w_tot_nxt;
                r_ovf_lat <= w_ovf_nxt;
                r_win_idx <= r_win_idx + 16'd1;
                for (int b = 0; b < NUM_BINS; b++) begin
                    r_bank[b] <= w_bins_nxt[b];
                end
            end
        end
    end

    assign light_out    = r_light;
    assign bin_count    = r_bank[bin_sel];
    assign i_value      = r_i_value;
    assign q_value      = r_q_value;
    assign total_count  = r_total;
    assign result_valid = r_valid;
    assign overflow     = r_ovf_lat;
    assign window_index = r_win_idx;

endmodule

// File: tb/tb_photon_lockin_counter.sv
// Bench for photon_lockin_counter with an 8-cycle period, 4 bins, 4-bit counters, 64-cycle windows.
// Stimulus runs one directed sequence; a per-window model pushes expected results that a monitor pops.
// The monitor also checks that latched outputs hold steady between result pulses.
module tb_photon_lockin_counter;

    localparam int P  = 8;
    localparam int W  = 64;
    localparam int NW = 8;

    logic              main_clock = 1'b0;
    logic              reset;
    logic              pmt_in;
    logic              light_out;
    logic [1:0]        bin_sel = 2'd0;
    logic [3:0]        bin_count;
    logic signed [4:0] i_value;
    logic signed [4:0] q_value;
    logic [3:0]        total_count;
    logic              result_valid;
    logic              overflow;
    logic [15:0]       window_index;

    photon_lockin_counter #(
        .PERIOD_CYCLES(P),
        .NUM_BINS(4),
        .COUNT_W(4),
        .INTEG_CYCLES(W)
    ) dut (
        .main_clock(main_clock),
        .reset(reset),
        .pmt_in(pmt_in),
        .light_out(light_out),
        .bin_sel(bin_sel),
        .bin_count(bin_count),
        .i_value(i_value),
        .q_value(q_value),
        .total_count(total_count),
        .result_valid(result_valid),
        .overflow(overflow),
        .window_index(window_index)
    );

    always #5 main_clock = ~main_clock;

    typedef struct packed {
        int i;
        int q;
        int tot;
        int ovf;
        int wi;
        logic [3:0][31:0] b;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp = '0;

    int checks   = 0;
    int failures = 0;
    int cnt      = 0;
    int pushes   = 0;
    int pops     = 0;
    int rv_total = 0;
    int rv_mark  = 0;
    bit prev_rv  = 1'b0;

    int m_ip [NW];
    int m_im [NW];
    int m_qp [NW];
    int m_qm [NW];
    int m_tot[NW];
    int m_ovf[NW];
    int m_bin[NW][4];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
        end
    endtask

    function automatic void clear_model();
        for (int w = 0; w < NW; w++) begin
            m_ip[w] = 0; m_im[w] = 0; m_qp[w] = 0; m_qm[w] = 0;
            m_tot[w] = 0; m_ovf[w] = 0;
            for (int k = 0; k < 4; k++) m_bin[w][k] = 0;
        end
    endfunction

    function automatic int bump(input int v, input int w);
        if (v >= 15) begin
            m_ovf[w] = 1;
            return 15;
        end
        return v + 1;
    endfunction

    // Record one photon event landing on absolute cycle ec.
    function automatic void add_event(input int ec);
        int w;
        int ph;
        w  = ec / W;
        ph = ec % P;
        if (w < NW) begin
            if (ph < P/2) m_ip[w] = bump(m_ip[w], w);
            else          m_im[w] = bump(m_im[w], w);
            if (ph >= P/4 && ph < 3*P/4) m_qp[w] = bump(m_qp[w], w);
            else                         m_qm[w] = bump(m_qm[w], w);
            m_tot[w] = bump(m_tot[w], w);
            m_bin[w][ph/2] = bump(m_bin[w][ph/2], w);
        end
    endfunction

    function automatic void push(input int k);
        exp_t e;
        e.i   = m_ip[k] - m_im[k];
        e.q   = m_qp[k] - m_qm[k];
        e.tot = m_tot[k];
        e.ovf = m_ovf[k];
        e.wi  = (k + 1) % 65536;
        for (int j = 0; j < 4; j++) e.b[j] = m_bin[k][j];
        sb_q.push_back(e);
        pushes++;
    endfunction

    // One clock; cnt is the number of post-reset edges seen.
    task automatic step();
        @(posedge main_clock);
        #1;
        if (!reset) begin
            cnt++;
            if ((cnt % W) == W - 1 && (cnt / W) < NW) push(cnt / W);
        end
    endtask

    task automatic wait_until(input int c);
        while (cnt < c) step();
    endtask

    // Raise pmt_in so the resulting event lands on phase p.
    task automatic pulse_at(input int p);
        int n;
        n = 0;
        while (((cnt + 2) % P) != p && n < 2*P) begin
            step();
            n++;
        end
        add_event(cnt + 2);
        pmt_in = 1'b1;
        step();
        pmt_in = 1'b0;
        step();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_i"},   i_value, 0);
        chk({tag, "_q"},   q_value, 0);
        chk({tag, "_tot"}, total_count, 0);
        chk({tag, "_wi"},  window_index, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_rv"},  result_valid, 0);
        chk({tag, "_lt"},  light_out, 0);
    endtask

    // Monitor: pop and compare on result_valid, otherwise require held outputs.
    always @(negedge main_clock) begin
        if (reset) begin
            last_exp = '0;
            prev_rv  = 1'b0;
        end else if (result_valid) begin
            exp_t e;
            rv_total++;
            chk("rv_one_cycle", prev_rv, 0);
            chk("rv_expected", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                pops++;
                chk("res_i",   i_value, e.i);
                chk("res_q",   q_value, e.q);
                chk("res_tot", total_count, e.tot);
                chk("res_ovf", overflow, e.ovf);
                chk("res_wi",  window_index, e.wi);
                for (int k = 0; k < 4; k++) begin
                    bin_sel = 2'(k);
                    #1;
                    chk($sformatf("res_bin%0d", k), bin_count, e.b[k]);
                end
                last_exp = e;
            end
            prev_rv = 1'b1;
        end else begin
            chk("hold_i",   i_value, last_exp.i);
            chk("hold_tot", total_count, last_exp.tot);
            chk("hold_wi",  window_index, last_exp.wi);
            chk("hold_ovf", overflow, last_exp.ovf);
            prev_rv = 1'b0;
        end
    end

    initial begin
        reset  = 1'b1;
        pmt_in = 1'b0;
        clear_model();
        repeat (3) step();
        reset = 1'b0;
        cnt   = 0;
        check_zero("rst");
        chk("rst_bin0", bin_count, 0);

        // Window 0: empty, light modulation pattern checked every cycle.
        while (cnt < W) begin
            chk($sformatf("light_c%0d", cnt), light_out,
                (cnt == 0) ? 0 : ((((cnt - 1) % P) < P/2) ? 1 : 0));
            step();
        end
        step();
        chk("rv_width", result_valid, 0);

        // Window 1: three events at phase 1, two at phase 5.
        repeat (3) pulse_at(1);
        repeat (2) pulse_at(5);

        // Window 2: sixteen in-phase events saturate I+ and total.
        wait_until(2*W - 2);
        repeat (8) begin
            pulse_at(0);
            pulse_at(2);
        end

        // Window 3 stays empty; window 4 gets one event on its last cycle.
        wait_until(5*W - 3);
        pulse_at(7);

        // Window 6: four events, then reset at window cycle 40.
        wait_until(6*W);
        pulse_at(1);
        pulse_at(3);
        pulse_at(5);
        pulse_at(7);
        wait_until(6*W + 40);
        rv_mark = rv_total;
        reset  = 1'b1;
        pmt_in = 1'b1;
        clear_model();
        repeat (3) step();
        check_zero("abort");
        reset = 1'b0;
        cnt   = 0;
        check_zero("rel");
        repeat (4) step();
        pmt_in = 1'b0;
        step();
        wait_until(10);
        pulse_at(2);
        pulse_at(4);
        wait_until(W + 2);
        chk("abort_no_rv", rv_total - rv_mark, 1);

        chk("sb_empty", sb_q.size(), 0);
        chk("sb_pops", pops, pushes);
        chk("sb_count", pops, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
